sg_norm_pipe: RTL and testbench

SG_NORM_PIPE -- requirements
Module: sg_norm_pipe

---
 rtl/sg_pkg.sv | 17 +
 rtl/sg_lead_one.sv | 24 ++
 rtl/sg_norm_pipe.sv | 140 ++++++++++++++
 tb/tb_sg_norm_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sg_pkg.sv
// Shared defaults and the width helper for the significand normaliser.
package sg_pkg;
  localparam int SG_WIDTH = 22;
  localparam int SG_EXP_W = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/sg_lead_one.sv
// Leading-one detector: index of the highest set bit, WIDTH-1 with zero=1 when empty.
module sg_lead_one
  import sg_pkg::*;
#(
  parameter int WIDTH = SG_WIDTH,
  parameter int CNT_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] sig,
  output logic [CNT_W-1:0] index,
  output logic             zero
);

  always_comb begin
    index = CNT_W'(WIDTH - 1);
    zero  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (sig[i]) begin
        index = CNT_W'(i);
        zero  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sg_norm_pipe.sv
// Two-stage significand normaliser: S1 finds the leading one, S2 shifts and
// adjusts the exponent, clamping at zero and flagging underflow.
module sg_norm_pipe
  import sg_pkg::*;
#(
  parameter int WIDTH = SG_WIDTH,
  parameter int EXP_W = SG_EXP_W,
  parameter int CNT_W = clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sig,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sig,
  output logic [EXP_W-1:0] out_exp,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero,
  output logic             out_uflow
);

  localparam int AW = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 1;

  // Returns {underflow, exponent}; the exponent saturates at zero.
  function automatic logic [EXP_W:0] sat_exp(input logic [EXP_W-1:0] e,
                                             input logic [CNT_W-1:0] sh);
    logic [AW-1:0] diff;
    diff = AW'(e) - AW'(sh);
    if (diff[AW-1]) return {1'b1, {EXP_W{1'b0}}};
    return {1'b0, diff[EXP_W-1:0]};
  endfunction

  logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] sig_p1_q, sig_p1_d, sig_p2_q, sig_p2_d;
  logic [EXP_W-1:0] exp_p1_q, exp_p1_d, exp_p2_q, exp_p2_d;
  logic [CNT_W-1:0] idx_p1_q, idx_p1_d, cnt_p2_q, cnt_p2_d;
  logic             zero_p1_q, zero_p1_d, zero_p2_q, zero_p2_d;
  logic             uflow_p2_q, uflow_p2_d;
  logic [CNT_W-1:0] lo_index;
  logic             lo_zero;
  logic             s1_moves;
  logic [CNT_W-1:0] shift;
  logic [CNT_W-1:0] shamt;
  logic [EXP_W:0]   adj;

  assign s1_moves = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || s1_moves;

  // Stage 1: leading-one detection on the incoming significand
  sg_lead_one #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lead_one (
    .sig  (in_sig),
    .index(lo_index),
    .zero (lo_zero)
  );

  always_comb begin
    vld_p1_d  = vld_p1_q;
    sig_p1_d  = sig_p1_q;
    exp_p1_d  = exp_p1_q;
    idx_p1_d  = idx_p1_q;
    zero_p1_d = zero_p1_q;
    if (in_ready) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        sig_p1_d  = in_sig;
        exp_p1_d  = in_exp;
        idx_p1_d  = lo_index;
        zero_p1_d = lo_zero;
      end
    end
  end

  // Stage 2: normalising shift and exponent adjustment
  always_comb begin
    shift      = CNT_W'(WIDTH - 1) - idx_p1_q;
    adj        = sat_exp(exp_p1_q, shift);
    shamt      = adj[EXP_W] ? CNT_W'(exp_p1_q) : shift;
    vld_p2_d   = vld_p2_q;
    sig_p2_d   = sig_p2_q;
    exp_p2_d   = exp_p2_q;
    cnt_p2_d   = cnt_p2_q;
    zero_p2_d  = zero_p2_q;
    uflow_p2_d = uflow_p2_q;
    if (s1_moves) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        cnt_p2_d  = idx_p1_q;
        zero_p2_d = zero_p1_q;
        if (zero_p1_q) begin
          sig_p2_d   = '0;
          exp_p2_d   = '0;
          uflow_p2_d = 1'b0;
        end else begin
          sig_p2_d   = sig_p1_q << shamt;
          exp_p2_d   = adj[EXP_W-1:0];
          uflow_p2_d = adj[EXP_W];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      sig_p2_q   <= '0;
      exp_p2_q   <= '0;
      cnt_p2_q   <= CNT_W'(WIDTH - 1);
      zero_p2_q  <= 1'b0;
      uflow_p2_q <= 1'b0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      sig_p2_q   <= sig_p2_d;
      exp_p2_q   <= exp_p2_d;
      cnt_p2_q   <= cnt_p2_d;
      zero_p2_q  <= zero_p2_d;
      uflow_p2_q <= uflow_p2_d;
    end
  end

  // S1 payload is qualified by vld_p1_q, so it carries no reset
  always_ff @(posedge clock) begin
    sig_p1_q  <= sig_p1_d;
    exp_p1_q  <= exp_p1_d;
    idx_p1_q  <= idx_p1_d;
    zero_p1_q <= zero_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_sig   = sig_p2_q;
  assign out_exp   = exp_p2_q;
  assign out_count = cnt_p2_q;
  assign out_zero  = zero_p2_q;
  assign out_uflow = uflow_p2_q;

endmodule

// File: tb/tb_sg_norm_pipe.sv
// Bench for sg_norm_pipe: directed vectors, stall, random traffic and
// mid-stream reset against an arithmetic reference model with a scoreboard queue.
module tb_sg_norm_pipe;
  localparam int W  = 22;
  localparam int EW = 8;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_sig;
  logic [EW-1:0] in_exp;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sig;
  logic [EW-1:0] out_exp;
  logic [CW-1:0] out_count;
  logic          out_zero;
  logic          out_uflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]  sig;
    logic [EW-1:0] exp;
    logic [CW-1:0] cnt;
    logic          zero;
    logic          uflow;
  } res_t;

  res_t q[$];

  always #5 clock = ~clock;

  sg_norm_pipe dut (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sig   (in_sig),
    .in_exp   (in_exp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sig  (out_sig),
    .out_exp  (out_exp),
    .out_count(out_count),
    .out_zero (out_zero),
    .out_uflow(out_uflow)
  );

  function automatic res_t model(input logic [W-1:0] s, input logic [EW-1:0] e);
    res_t   r;
    longint v;
    longint wide;
    int     top;
    int     sh;
    v = longint'(s);
    top = -1;
    while (v != 0) begin
      v = v >> 1;
      top++;
    end
    if (top < 0) begin
      r.sig = '0; r.exp = '0; r.cnt = CW'(W - 1); r.zero = 1'b1; r.uflow = 1'b0;
      return r;
    end
    sh = W - 1 - top;
    r.cnt  = CW'(top);
    r.zero = 1'b0;
    if (sh <= int'(e)) begin
      r.exp = EW'(int'(e) - sh); r.uflow = 1'b0; wide = longint'(s) << sh;
    end else begin
      r.exp = '0; r.uflow = 1'b1; wide = longint'(s) << e;
    end
    r.sig = wide[W-1:0];
    return r;
  endfunction

  task automatic drive_cycle(input logic v, input logic [W-1:0] s, input logic [EW-1:0] e,
                             input logic ordy, output logic in_acc, output logic out_acc);
    res_t x;
    @(negedge clock);
    in_valid = v; in_sig = s; in_exp = e; out_ready = ordy;
    #1;
    in_acc  = in_valid && in_ready;
    out_acc = out_valid && out_ready;
    if (out_acc) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got sig=%h exp=%0d with nothing expected", out_sig, out_exp);
      end else begin
        x = q.pop_front();
        if ({out_sig, out_exp, out_count, out_zero, out_uflow} !== {x.sig, x.exp, x.cnt, x.zero, x.uflow}) begin
          errors++;
          $display("FAIL scoreboard: got sig=%h exp=%0d cnt=%0d z=%b uf=%b required sig=%h exp=%0d cnt=%0d z=%b uf=%b",
                   out_sig, out_exp, out_count, out_zero, out_uflow, x.sig, x.exp, x.cnt, x.zero, x.uflow);
        end
      end
    end
    if (in_acc) q.push_back(model(s, e));
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_sig = '0; in_exp = '0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (out_sig !== '0) begin errors++; $display("FAIL rst_out_sig: got %h required 0", out_sig); end
    checks++; if (out_exp !== '0) begin errors++; $display("FAIL rst_out_exp: got %0d required 0", out_exp); end
    checks++; if (out_count !== CW'(21)) begin errors++; $display("FAIL rst_out_count: got %0d required 21", out_count); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL rst_out_zero: got %b required 0", out_zero); end
    checks++; if (out_uflow !== 1'b0) begin errors++; $display("FAIL rst_out_uflow: got %b required 0", out_uflow); end
    @(negedge clock);
    resetn = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [W-1:0]  t_sig [4] = '{22'h200000, 22'h000010, 22'h000001, 22'h000000};
    logic [EW-1:0] t_exp [4] = '{8'd100, 8'd100, 8'd5, 8'd50};
    logic [W-1:0]  e_sig [4] = '{22'h200000, 22'h200000, 22'h000020, 22'h000000};
    logic [EW-1:0] e_exp [4] = '{8'd100, 8'd83, 8'd0, 8'd0};
    logic [CW-1:0] e_cnt [4] = '{5'd21, 5'd4, 5'd0, 5'd21};
    logic          e_uf  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic          e_z   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic ia, oa;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, t_sig[i], t_exp[i], 1'b1, ia, oa);
      lat = 0;
      for (int c = 1; c <= 6 && lat == 0; c++) begin
        drive_cycle(1'b0, '0, '0, 1'b1, ia, oa);
        if (oa) begin
          lat = c;
          checks++;
          if ({out_sig, out_exp, out_count, out_uflow, out_zero} !== {e_sig[i], e_exp[i], e_cnt[i], e_uf[i], e_z[i]}) begin
            errors++;
            $display("FAIL directed_%0d: got sig=%h exp=%0d cnt=%0d uf=%b z=%b required sig=%h exp=%0d cnt=%0d uf=%b z=%b",
                     i, out_sig, out_exp, out_count, out_uflow, out_zero, e_sig[i], e_exp[i], e_cnt[i], e_uf[i], e_z[i]);
          end
        end
      end
      checks++;
      if (lat != 2) begin errors++; $display("FAIL latency_%0d: got %0d cycles required 2", i, lat); end
    end
  endtask

  task automatic test_stall();
    logic          ia, oa, ordy;
    logic          held;
    logic          saw_block;
    logic [W-1:0]  snap_sig;
    logic [EW-1:0] snap_exp;
    logic [CW-1:0] snap_cnt;
    logic          snap_z, snap_uf;
    logic [W-1:0]  s [10];
    logic [EW-1:0] e [10];
    int n, outs, cyc;
    for (int i = 0; i < 10; i++) begin
      s[i] = W'($urandom);
      e[i] = EW'($urandom_range(0, 255));
    end
    n = 0; outs = 0; cyc = 0; held = 1'b0; saw_block = 1'b0;
    while ((n < 10 || q.size() != 0) && cyc < 200) begin
      ordy = !(cyc >= 3 && cyc <= 6);
      drive_cycle(n < 10, (n < 10) ? s[n] : '0, (n < 10) ? e[n] : '0, ordy, ia, oa);
      if (held) begin
        checks++;
        if (!out_valid || {out_sig, out_exp, out_count, out_zero, out_uflow} !== {snap_sig, snap_exp, snap_cnt, snap_z, snap_uf}) begin
          errors++;
          $display("FAIL stall_stable: got v=%b sig=%h exp=%0d required v=1 sig=%h exp=%0d", out_valid, out_sig, out_exp, snap_sig, snap_exp);
        end
      end
      if (n < 10 && !in_ready) begin
        saw_block = 1'b1;
        checks++;
        if (!out_valid) begin errors++; $display("FAIL stall_ready: got in_ready=0 with out_valid=0 required in_ready=1"); end
      end
      held = out_valid && !out_ready;
      snap_sig = out_sig; snap_exp = out_exp; snap_cnt = out_count; snap_z = out_zero; snap_uf = out_uflow;
      if (ia) n++;
      if (oa) outs++;
      cyc++;
    end
    checks++; if (!saw_block) begin errors++; $display("FAIL stall_backpressure: got in_ready never 0 required 0 when both stages full"); end
    checks++; if (outs != 10) begin errors++; $display("FAIL stall_count: got %0d outputs required 10", outs); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d pending required 0", q.size()); end
  endtask

  task automatic test_random();
    logic ia, oa;
    logic [W-1:0]  s;
    logic [EW-1:0] e;
    int k, outs, ins;
    outs = 0; ins = 0;
    for (int c = 0; c < 400; c++) begin
      k = $urandom_range(0, W);
      s = W'(longint'($urandom) & ((longint'(1) << k) - 1));
      e = ($urandom_range(0, 1) == 1) ? EW'($urandom_range(0, 25)) : EW'($urandom_range(0, 255));
      drive_cycle($urandom_range(0, 3) != 0, s, e, $urandom_range(0, 3) != 0, ia, oa);
      if (ia) ins++;
      if (oa) outs++;
    end
    for (int c = 0; c < 20 && q.size() != 0; c++) begin
      drive_cycle(1'b0, '0, '0, 1'b1, ia, oa);
      if (oa) outs++;
    end
    checks++; if (outs != ins) begin errors++; $display("FAIL random_count: got %0d outputs required %0d", outs, ins); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL random_drain: got %0d pending required 0", q.size()); end
  endtask

  task automatic test_back_to_back();
    logic ia, oa;
    int ins, outs, bubbles;
    ins = 0; outs = 0; bubbles = 0;
    for (int c = 0; c < 30; c++) begin
      drive_cycle(1'b1, W'($urandom), EW'($urandom), 1'b1, ia, oa);
      if (ia) ins++;
      if (oa) outs++;
      if (c >= 2 && !(ia && oa)) bubbles++;
    end
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      drive_cycle(1'b0, '0, '0, 1'b1, ia, oa);
      if (oa) outs++;
    end
    checks++; if (bubbles != 0) begin errors++; $display("FAIL b2b_bubbles: got %0d required 0", bubbles); end
    checks++; if (outs != ins) begin errors++; $display("FAIL b2b_count: got %0d required %0d", outs, ins); end
  endtask

  task automatic test_midstream_reset();
    logic ia, oa;
    int outs;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, W'($urandom), EW'($urandom), 1'b0, ia, oa);
    @(negedge clock);
    in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    q.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b required 0", out_valid); end
    checks++; if (out_count !== CW'(21)) begin errors++; $display("FAIL mid_rst_count: got %0d required 21", out_count); end
    checks++; if (out_sig !== '0) begin errors++; $display("FAIL mid_rst_sig: got %h required 0", out_sig); end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b required 1", in_ready); end
    outs = 0;
    drive_cycle(1'b1, 22'h001234, 8'd40, 1'b1, ia, oa);
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b0, '0, '0, 1'b1, ia, oa);
      if (oa) outs++;
    end
    checks++; if (outs != 1) begin errors++; $display("FAIL mid_rst_outputs: got %0d required 1", outs); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_random();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
